lcd_sprite_seq: RTL and testbench

Parametrised command sequencer for the PCD8544 (84x48, Nokia 5110) LCD, sitting between top-level control logic and `spi_master`. After reset it runs the panel init sequence and a full-screen clear, then places an arbitrary-size sprite, read from an external synchronous ROM, at a requested column/bank position. Any part of the sprite that falls outside the panel is clipped. It generalises the fixed-sprite configuration FSM into a table-driven engine with runtime position, clear-on-demand and a done handshake.

---
 rtl/lcd_sprite_seq.sv | 272 +++++++++++++++++++++++++++
 tb/tb_lcd_sprite_seq.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/lcd_sprite_seq.sv
// PCD8544 command sequencer: init, full clear, clipped sprite blit from sync ROM.
// Optional LCD_SEQ_MIRROR_EN adds a horizontal-flip input `mirror`.
module lcd_sprite_seq #(
  parameter int SPR_W     = 16,
  parameter int SPR_BANKS = 2,
  parameter int LCD_COLS  = 84,
  parameter int LCD_BANKS = 6,
  parameter int AW        = $clog2(SPR_W*SPR_BANKS)
) (
  input  logic          clock,
  input  logic          Reset,
  input  logic          draw_req,
  input  logic          clear_req,
  input  logic [6:0]    pos_x,
  input  logic [2:0]    pos_y,
`ifdef LCD_SEQ_MIRROR_EN
  input  logic          mirror,
`endif
  output logic [AW-1:0] spr_addr,
  input  logic [7:0]    spr_data,
  output logic [7:0]    spi_data,
  output logic          spi_cmd,
  output logic          spi_start,
  input  logic          spi_avail,
  output logic          busy,
  output logic          done
);

  localparam int CLR_N = LCD_COLS*LCD_BANKS;

  typedef enum logic [2:0] {
    INIT, CLR_ADDR, CLR_DATA, IDLE,
    D_ADDR, D_FETCH, D_SEND
  } state_t;

  state_t state, state_n;
  logic [8:0] idx, idx_n;
  logic [2:0] bank, bank_n;
  logic [7:0] x_r, x_n, y_r, y_n;
  logic [7:0] cols_r, cols_n;
  logic [7:0] banks_r, banks_n;
  logic clr_r, clr_n;
  logic start_r, start_n;
  logic cmd_r, cmd_n;
  logic [7:0] data_r, data_n;
  logic [AW-1:0] addr_r, addr_n;
  logic done_r, done_n;
  logic busy_r, busy_n;
  logic fetch;
  logic [7:0] fcol, src;
  logic [7:0] rem_x, rem_y;
`ifdef LCD_SEQ_MIRROR_EN
  logic mir_r, mir_n;
`endif

  function automatic logic [7:0] init_byte(
    input logic [1:0] i);
    unique case (i)
      2'd0:    return 8'h21;
      2'd1:    return 8'h90;
      2'd2:    return 8'h20;
      default: return 8'h0C;
    endcase
  endfunction

  always_ff @(posedge clock) begin
    if (Reset) begin
      state   <= INIT;
      idx     <= '0;
      bank    <= '0;
      x_r     <= '0;
      y_r     <= '0;
      cols_r  <= '0;
      banks_r <= '0;
      clr_r   <= 1'b0;
      start_r <= 1'b0;
      cmd_r   <= 1'b0;
      data_r  <= '0;
      addr_r  <= '0;
      done_r  <= 1'b0;
      busy_r  <= 1'b1;
`ifdef LCD_SEQ_MIRROR_EN
      mir_r   <= 1'b0;
`endif
    end else begin
      state   <= state_n;
      idx     <= idx_n;
      bank    <= bank_n;
      x_r     <= x_n;
      y_r     <= y_n;
      cols_r  <= cols_n;
      banks_r <= banks_n;
      clr_r   <= clr_n;
      start_r <= start_n;
      cmd_r   <= cmd_n;
      data_r  <= data_n;
      addr_r  <= addr_n;
      done_r  <= done_n;
      busy_r  <= busy_n;
`ifdef LCD_SEQ_MIRROR_EN
      mir_r   <= mir_n;
`endif
    end
  end

  always_comb begin
    state_n = state;
    idx_n   = idx;
    bank_n  = bank;
    x_n     = x_r;
    y_n     = y_r;
    cols_n  = cols_r;
    banks_n = banks_r;
    clr_n   = clr_r;
    start_n = start_r;
    cmd_n   = cmd_r;
    data_n  = data_r;
    addr_n  = addr_r;
    done_n  = 1'b0;
    fetch   = 1'b0;
    fcol    = '0;
    src     = '0;
    rem_x   = '0;
    rem_y   = '0;
`ifdef LCD_SEQ_MIRROR_EN
    mir_n   = mir_r;
`endif
    unique case (state)
      INIT: begin
        // start_r low means we just left reset
        if (!start_r) begin
          start_n = 1'b1;
          cmd_n   = 1'b0;
          data_n  = init_byte(idx[1:0]);
        end else if (spi_avail) begin
          if (idx == 9'd3) begin
            state_n = CLR_ADDR;
            idx_n   = '0;
            data_n  = 8'h80;
          end else begin
            idx_n  = idx + 9'd1;
            data_n = init_byte(idx[1:0] + 2'd1);
          end
        end
      end
      CLR_ADDR: begin
        if (spi_avail) begin
          if (idx == 9'd0) begin
            idx_n  = 9'd1;
            data_n = 8'h40;
          end else begin
            state_n = CLR_DATA;
            idx_n   = '0;
            cmd_n   = 1'b1;
            data_n  = 8'h00;
          end
        end
      end
      CLR_DATA: begin
        if (spi_avail) begin
          if (idx == 9'(CLR_N-1)) begin
            state_n = IDLE;
            start_n = 1'b0;
            done_n  = clr_r;
            clr_n   = 1'b0;
          end else begin
            idx_n = idx + 9'd1;
          end
        end
      end
      IDLE: begin
        start_n = 1'b0;
        if (clear_req) begin
          state_n = CLR_ADDR;
          idx_n   = '0;
          clr_n   = 1'b1;
          start_n = 1'b1;
          cmd_n   = 1'b0;
          data_n  = 8'h80;
        end else if (draw_req) begin
          state_n = D_ADDR;
          idx_n   = '0;
          bank_n  = '0;
          x_n     = {1'b0, pos_x};
          y_n     = {5'b0, pos_y};
          rem_x   = 8'(LCD_COLS) - x_n;
          rem_y   = 8'(LCD_BANKS) - y_n;
`ifdef LCD_SEQ_MIRROR_EN
          mir_n   = mirror;
`endif
          if (x_n >= 8'(LCD_COLS) ||
              y_n >= 8'(LCD_BANKS)) begin
            cols_n  = '0;
            banks_n = '0;
          end else begin
            cols_n  = (rem_x < 8'(SPR_W)) ?
                      rem_x : 8'(SPR_W);
            banks_n = (rem_y < 8'(SPR_BANKS)) ?
                      rem_y : 8'(SPR_BANKS);
            start_n = 1'b1;
            cmd_n   = 1'b0;
            data_n  = 8'h80 | x_n;
          end
        end
      end
      D_ADDR: begin
        // banks_r==0 marks a fully clipped draw
        if (banks_r == 8'd0) begin
          state_n = IDLE;
          start_n = 1'b0;
          done_n  = 1'b1;
        end else if (spi_avail) begin
          if (idx == 9'd0) begin
            idx_n  = 9'd1;
            data_n = 8'h40 | (y_r + {5'b0, bank});
          end else begin
            state_n = D_FETCH;
            idx_n   = '0;
            start_n = 1'b0;
            fetch   = 1'b1;
            fcol    = 8'd0;
          end
        end
      end
      D_FETCH: begin
        state_n = D_SEND;
        start_n = 1'b1;
        cmd_n   = 1'b1;
      end
      D_SEND: begin
        if (spi_avail) begin
          if (idx[7:0] == cols_r - 8'd1) begin
            if ({5'b0, bank} == banks_r - 8'd1) begin
              state_n = IDLE;
              start_n = 1'b0;
              done_n  = 1'b1;
            end else begin
              state_n = D_ADDR;
              bank_n  = bank + 3'd1;
              idx_n   = '0;
              cmd_n   = 1'b0;
              data_n  = 8'h80 | x_r;
            end
          end else begin
            state_n = D_FETCH;
            idx_n   = idx + 9'd1;
            start_n = 1'b0;
            fetch   = 1'b1;
            fcol    = idx[7:0] + 8'd1;
          end
        end
      end
      default: state_n = INIT;
    endcase
    src = fcol;
`ifdef LCD_SEQ_MIRROR_EN
    if (mir_r) src = 8'(SPR_W-1) - fcol;
`endif
    if (fetch)
      addr_n = AW'(16'(bank)*16'(SPR_W) + 16'(src));
    busy_n = (state_n != IDLE);
  end

  // ROM data is already registered, so it feeds the SPI byte directly
  assign spi_data  = (state == D_SEND) ? spr_data : data_r;
  assign spi_cmd   = cmd_r;
  assign spi_start = start_r;
  assign spr_addr  = addr_r;
  assign busy      = busy_r;
  assign done      = done_r;

endmodule

// File: tb/tb_lcd_sprite_seq.sv
// Directed bench for lcd_sprite_seq with a delayed-accept SPI master model.
// Define LCD_SEQ_MIRROR_EN to also exercise the mirror input.
module tb_lcd_sprite_seq;

  logic clock = 0;
  logic Reset;
  logic draw_req, clear_req;
  logic [6:0] pos_x;
  logic [2:0] pos_y;
  logic [4:0] spr_addr;
  logic [7:0] spr_data;
  logic [7:0] spi_data;
  logic spi_cmd, spi_start;
  logic spi_avail;
  logic busy, done;
`ifdef LCD_SEQ_MIRROR_EN
  logic mirror;
`endif

  lcd_sprite_seq dut (
    .clock     (clock),
    .Reset     (Reset),
    .draw_req  (draw_req),
    .clear_req (clear_req),
    .pos_x     (pos_x),
    .pos_y     (pos_y),
`ifdef LCD_SEQ_MIRROR_EN
    .mirror    (mirror),
`endif
    .spr_addr  (spr_addr),
    .spr_data  (spr_data),
    .spi_data  (spi_data),
    .spi_cmd   (spi_cmd),
    .spi_start (spi_start),
    .spi_avail (spi_avail),
    .busy      (busy),
    .done      (done)
  );

  always #5 clock = ~clock;

  logic [7:0] rom [32];
  initial for (int i = 0; i < 32; i++) rom[i] = 8'(i);
  always @(posedge clock) spr_data <= rom[spr_addr];

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;
  int wcnt = 0;
  logic [8:0] cap [$];
  logic [8:0] exp_q [$];

  // master: accept each byte 4 cycles after spi_start, record {cmd,data}
  initial spi_avail = 0;
  always @(negedge clock) begin
    if (Reset) begin
      spi_avail = 0;
      wcnt = 0;
    end else if (spi_avail) begin
      spi_avail = 0;
      wcnt = 0;
    end else if (spi_start) begin
      wcnt++;
      if (wcnt == 4) begin
        spi_avail = 1;
        cap.push_back({spi_cmd, spi_data});
      end
    end else begin
      wcnt = 0;
    end
    if (done) done_cnt++;
  end

  task automatic chk(input string name, input int act, input int exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  function automatic void build_clear(input bit with_init);
    exp_q.delete();
    if (with_init) begin
      exp_q.push_back(9'h021);
      exp_q.push_back(9'h090);
      exp_q.push_back(9'h020);
      exp_q.push_back(9'h00C);
    end
    exp_q.push_back(9'h080);
    exp_q.push_back(9'h040);
    for (int i = 0; i < 504; i++) exp_q.push_back(9'h100);
  endfunction

  function automatic void build_draw(input int x, input int y,
                                     input bit mir);
    int nc, nb, a;
    exp_q.delete();
    if (x < 84 && y < 6) begin
      nc = (84 - x < 16) ? 84 - x : 16;
      nb = (6 - y < 2) ? 6 - y : 2;
      for (int b = 0; b < nb; b++) begin
        exp_q.push_back(9'(8'h80 | x));
        exp_q.push_back(9'(8'h40 | (y + b)));
        for (int c = 0; c < nc; c++) begin
          a = b * 16 + (mir ? 15 - c : c);
          exp_q.push_back(9'h100 | 9'(a));
        end
      end
    end
  endfunction

  task automatic cmp_stream(input string name);
    chk({name, " len"}, cap.size(), exp_q.size());
    for (int i = 0; i < exp_q.size() && i < cap.size(); i++)
      chk($sformatf("%s[%0d]", name, i), int'(cap[i]), int'(exp_q[i]));
  endtask

  task automatic wait_idle(input string name, input int budget);
    int k = 0;
    while (busy && k < budget) begin
      @(negedge clock); #1;
      k++;
    end
    if (busy) chk({name, " idle timeout"}, 0, 1);
  endtask

  task automatic wait_done(input string name, input int budget);
    int k = 0;
    while (!done && k < budget) begin
      @(negedge clock); #1;
      k++;
    end
    if (!done) chk({name, " done timeout"}, 0, 1);
  endtask

  typedef struct {
    int x;
    int y;
    int n;
    int last;
  } vec_t;

  vec_t tbl [6];

  initial begin
    int d0, k;
    tbl[0] = '{10, 2, 36, 'h11F};
    tbl[1] = '{76, 5, 10, 'h107};
    tbl[2] = '{0,  0, 36, 'h11F};
    tbl[3] = '{83, 4, 6,  'h110};
    tbl[4] = '{0,  5, 18, 'h10F};
    tbl[5] = '{0,  7, 0,  0};

    Reset = 1;
    draw_req = 0;
    clear_req = 0;
    pos_x = 0;
    pos_y = 0;
`ifdef LCD_SEQ_MIRROR_EN
    mirror = 0;
`endif
    repeat (3) @(negedge clock);
    #1;
    chk("rst spi_start", spi_start, 0);
    chk("rst spi_cmd", spi_cmd, 0);
    chk("rst spi_data", spi_data, 0);
    chk("rst spr_addr", spr_addr, 0);
    chk("rst done", done, 0);
    chk("rst busy", busy, 1);
    Reset = 0;
    cap.delete();
    wait_idle("powerup", 6000);
    build_clear(1);
    cmp_stream("powerup");
    chk("powerup no done", done_cnt, 0);

    foreach (tbl[r]) begin
      cap.delete();
      d0 = done_cnt;
      pos_x = 7'(tbl[r].x);
      pos_y = 3'(tbl[r].y);
      draw_req = 1;
      @(negedge clock); #1;
      draw_req = 0;
      chk($sformatf("v%0d busy rise", r), busy, 1);
      chk($sformatf("v%0d start", r), spi_start, tbl[r].n > 0);
      wait_done($sformatf("v%0d", r), 2000);
      chk($sformatf("v%0d busy fall", r), busy, 0);
      repeat (5) @(negedge clock);
      #1;
      chk($sformatf("v%0d done cnt", r), done_cnt - d0, 1);
      chk($sformatf("v%0d bytes", r), cap.size(), tbl[r].n);
      if (tbl[r].n > 0 && cap.size() > 0)
        chk($sformatf("v%0d last", r), int'(cap[$]), tbl[r].last);
      build_draw(tbl[r].x, tbl[r].y, 0);
      cmp_stream($sformatf("v%0d", r));
    end

    // fully clipped on x: no bytes, done two cycles after request
    cap.delete();
    pos_x = 7'd90;
    pos_y = 3'd0;
    draw_req = 1;
    @(negedge clock); #1;
    draw_req = 0;
    chk("oob busy", busy, 1);
    chk("oob start", spi_start, 0);
    @(negedge clock); #1;
    chk("oob done", done, 1);
    chk("oob busy fall", busy, 0);
    chk("oob bytes", cap.size(), 0);

    // reset in the middle of a draw
    cap.delete();
    pos_x = 7'd10;
    pos_y = 3'd2;
    draw_req = 1;
    @(negedge clock); #1;
    draw_req = 0;
    k = 0;
    while (cap.size() < 5 && k < 500) begin
      @(negedge clock); #1;
      k++;
    end
    chk("midrst 5 bytes", cap.size(), 5);
    if (cap.size() >= 5) chk("midrst byte5", int'(cap[4]), 'h102);
    Reset = 1;
    @(negedge clock); #1;
    chk("midrst start", spi_start, 0);
    chk("midrst busy", busy, 1);
    Reset = 0;
    cap.delete();
    @(negedge clock); #1;
    chk("midrst restart", spi_start, 1);
    wait_idle("midrst", 6000);
    build_clear(1);
    cmp_stream("midrst");

    // clear and draw together: clear wins
    cap.delete();
    d0 = done_cnt;
    clear_req = 1;
    draw_req = 1;
    @(negedge clock); #1;
    clear_req = 0;
    draw_req = 0;
    wait_done("clr", 6000);
    repeat (5) @(negedge clock);
    #1;
    chk("clr done cnt", done_cnt - d0, 1);
    chk("clr busy", busy, 0);
    build_clear(0);
    cmp_stream("clr");

`ifdef LCD_SEQ_MIRROR_EN
    cap.delete();
    pos_x = 7'd0;
    pos_y = 3'd0;
    mirror = 1;
    draw_req = 1;
    @(negedge clock); #1;
    draw_req = 0;
    mirror = 0;
    wait_done("mir", 2000);
    repeat (5) @(negedge clock);
    #1;
    if (cap.size() > 2) chk("mir first", int'(cap[2]), 'h10F);
    if (cap.size() > 0) chk("mir last", int'(cap[$]), 'h110);
    build_draw(0, 0, 1);
    cmp_stream("mir");
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
